// File: rtl/if_stage.sv
// Fetch/memory-access stage of a multicycle MIPS-style datapath: PC register,
// PC+4 adder, and one unified instruction/data memory with address and write-data muxes.
module if_stage #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] entradaPC,
  input  logic [31:0] ALu,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic        PCescreve,
  input  logic        c1,
  input  logic        c2,
  input  logic        ler,
  input  logic        escreve,
  output logic [31:0] Pcsaida,
  output logic [31:0] SaidaDadosInstruc,
  output logic [31:0] writeDataMemWB,
  output logic [31:0] saidaAdder,
  output logic [31:0] saidaMemoria
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned DATA_W = 32;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] idx;

  // PC register: reset wins over the write enable
  always_ff @(posedge clock) begin
    if (reset) begin
      Pcsaida <= '0;
    end else if (PCescreve) begin
      Pcsaida <= entradaPC;
    end
  end

  assign saidaAdder        = Pcsaida + 32'd4;
  assign SaidaDadosInstruc = c1 ? Pcsaida : ALu;
  assign writeDataMemWB    = c2 ? data2 : data1;

  // Word index; upper address bits are dropped so addressing wraps
  assign idx = SaidaDadosInstruc[ADDR_W-1:0];

  // Memory contents survive reset; only the write itself is blocked
  always_ff @(posedge clock) begin
    if (!reset && escreve) begin
      mem[idx] <= writeDataMemWB;
    end
  end

  // Asynchronous read, forced to zero when not enabled
  assign saidaMemoria = ler ? mem[idx] : 32'd0;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by randomized
// traffic, all compared against a behavioural model of PC and memory.
module tb_if_stage;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic        clock;
  logic        reset;
  logic [31:0] entradaPC, ALu, data1, data2;
  logic        PCescreve, c1, c2, ler, escreve;
  logic [31:0] Pcsaida, SaidaDadosInstruc, writeDataMemWB, saidaAdder, saidaMemoria;

  if_stage #(.ADDR_W(ADDR_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .entradaPC        (entradaPC),
    .ALu              (ALu),
    .data1            (data1),
    .data2            (data2),
    .PCescreve        (PCescreve),
    .c1               (c1),
    .c2               (c2),
    .ler              (ler),
    .escreve          (escreve),
    .Pcsaida          (Pcsaida),
    .SaidaDadosInstruc(SaidaDadosInstruc),
    .writeDataMemWB   (writeDataMemWB),
    .saidaAdder       (saidaAdder),
    .saidaMemoria     (saidaMemoria)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [31:0] pc_m;
  logic [31:0] mem_m [DEPTH];
  bit          written [DEPTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned model_idx();
    logic [31:0] a;
    a = c1 ? pc_m : ALu;
    return int'(a % DEPTH);
  endfunction

  // Compare every output with the model for the current inputs
  task automatic check_all(input string tag);
    int unsigned i;
    i = model_idx();
    check({tag, ".pc"},    Pcsaida,           pc_m);
    check({tag, ".adder"}, saidaAdder,        pc_m + 32'd4);
    check({tag, ".addr"},  SaidaDadosInstruc, c1 ? pc_m : ALu);
    check({tag, ".wdata"}, writeDataMemWB,    c2 ? data2 : data1);
    if (!ler)
      check({tag, ".rd0"}, saidaMemoria, 32'd0);
    else if (written[i])
      check({tag, ".rd"},  saidaMemoria, mem_m[i]);
  endtask

  // One clock edge: check before, update model at the edge, check after
  task automatic tick(input string tag);
    int unsigned i;
    #1;
    check_all({tag, ".pre"});
    @(posedge clock);
    i = model_idx();
    if (reset) begin
      pc_m = 32'd0;
    end else begin
      if (escreve) begin
        mem_m[i]   = c2 ? data2 : data1;
        written[i] = 1'b1;
      end
      if (PCescreve) pc_m = entradaPC;
    end
    #1;
    check_all({tag, ".post"});
  endtask

  task automatic idle_inputs();
    reset = 0; PCescreve = 0; c1 = 0; c2 = 0; ler = 0; escreve = 0;
  endtask

  initial begin
    for (int k = 0; k < int'(DEPTH); k++) written[k] = 1'b0;
    idle_inputs();
    entradaPC = 32'd0; ALu = 32'd0; data1 = 32'd0; data2 = 32'd0;

    // 1. reset
    reset = 1;
    @(posedge clock);
    #1;
    pc_m = 32'd0;
    check("rst.pc",    Pcsaida,      32'd0);
    check("rst.adder", saidaAdder,   32'd4);
    check("rst.rd",    saidaMemoria, 32'd0);
    reset = 0;

    // 2. PC load then hold
    entradaPC = 32'h8000_1234; PCescreve = 1;
    tick("pcload");
    check("pcload.val",   Pcsaida,    32'h8000_1234);
    check("pcload.adder", saidaAdder, 32'h8000_1238);
    entradaPC = 32'h1111_1111; PCescreve = 0;
    tick("pchold");
    check("pchold.val", Pcsaida, 32'h8000_1234);

    // 3. Writes k=1..5 through ALu/data1
    escreve = 1;
    for (int k = 1; k <= 5; k++) begin
      ALu = 32'(k); data1 = 32'(k); data2 = 32'hDEAD_0000 + 32'(k);
      tick("wr");
      check("wr.addr",  SaidaDadosInstruc, 32'(k));
      check("wr.wdata", writeDataMemWB,    32'(k));
    end

    // 4. Readback and data2 select
    escreve = 0; ler = 1;
    for (int k = 1; k <= 5; k++) begin
      ALu = 32'(k);
      #1;
      check("rdback", saidaMemoria, 32'(k));
    end
    c2 = 1; data2 = 32'hCAFE_BABE;
    #1;
    check("c2sel", writeDataMemWB, 32'hCAFE_BABE);
    c2 = 0;

    // 5. PC-addressed fetch and index wrap
    entradaPC = 32'd3; PCescreve = 1;
    tick("pc3");
    PCescreve = 0; c1 = 1;
    #1;
    check("fetch.addr", SaidaDadosInstruc, 32'd3);
    check("fetch.rd",   saidaMemoria,      32'd3);
    c1 = 0; ALu = 32'h0000_0101;
    #1;
    check("wrap.rd", saidaMemoria, 32'd1);

    // 6a. Adder overflow
    entradaPC = 32'hFFFF_FFFC; PCescreve = 1;
    tick("pcmax");
    check("pcmax.adder", saidaAdder, 32'd0);
    PCescreve = 0;

    // 6b. Write during reset is dropped, PC cleared
    ALu = 32'd4; data1 = 32'd99; escreve = 1; reset = 1;
    tick("rstwr");
    reset = 0; escreve = 0;
    #1;
    check("rstwr.rd", saidaMemoria, 32'd4);
    check("rstwr.pc", Pcsaida,      32'd0);

    // 6c. Same-cycle read/write of idx 2
    ALu = 32'd2; data1 = 32'd7; escreve = 1; ler = 1;
    #1;
    check("rmw.before", saidaMemoria, 32'd2);
    tick("rmw");
    check("rmw.after", saidaMemoria, 32'd7);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 19) == 0);
      PCescreve = 1'($urandom);
      c1        = ($urandom_range(0, 3) == 0);
      c2        = 1'($urandom);
      ler       = 1'($urandom);
      escreve   = 1'($urandom);
      entradaPC = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 31)) : 32'($urandom);
      ALu       = {$urandom_range(0, 3) == 0 ? 24'($urandom) : 24'd0, 8'($urandom_range(0, 31))};
      data1     = $urandom;
      data2     = $urandom;
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
